// File: rtl/dmem_dump_reader_if.sv
// Bundle of the data-memory read port and the output word stream used by dmem_dump_reader.
// Output stream: a word transfers on a rising edge where out_valid & out_ready; out_valid is registered and
// out_data/out_last hold stable while out_valid=1 and out_ready=0.
interface dmem_dump_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] d_mem_addra;
    logic              d_mem_re;
    logic              d_mem_we;
    logic [DATA_W-1:0] d_mem_din;
    logic [DATA_W-1:0] d_mem_dout;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output d_mem_addra, d_mem_re, d_mem_we, d_mem_din,
        output out_data, out_valid, out_last,
        input  d_mem_dout, out_ready
    );

    modport slave (
        input  d_mem_addra, d_mem_re, d_mem_we, d_mem_din,
        input  out_data, out_valid, out_last,
        output d_mem_dout, out_ready
    );
endinterface

// File: rtl/dmem_dump_reader.sv
// Reads the word count at data-memory address 0, then streams words 1..N on a valid/ready
// output with a last flag; the count saturates at 2^ADDR_W-1 and flags cnt_clamped.
module dmem_dump_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    dmem_dump_reader_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 cnt_clamped,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CNT  = 3'd1,
        RD_WORD = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                clamp_q, clamp_d;
    logic                cnt_over;
    logic [ADDR_W-1:0]   cnt_in;
    logic                wait_done;

    // Any set bit above the address range means the count cannot be addressed; saturate it.
    assign cnt_over  = |bus.d_mem_dout[DATA_W-1:ADDR_W];
    assign cnt_in    = cnt_over ? {ADDR_W{1'b1}} : bus.d_mem_dout[ADDR_W-1:0];
    assign wait_done = (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            clamp_q <= clamp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        clamp_d = clamp_q;

        if (abort) begin
            // out_data deliberately survives an abort; only the stream qualifiers drop.
            state_d = IDLE;
            wait_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RD_CNT;
                        addr_d  = '0;
                        wait_d  = '0;
                        clamp_d = 1'b0;
                    end
                end
                RD_CNT: begin
                    if (wait_done) begin
                        wait_d  = '0;
                        cnt_d   = cnt_in;
                        clamp_d = cnt_over;
                        if (cnt_in == '0) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = ADDR_W'(1);
                            addr_d  = ADDR_W'(1);
                            state_d = RD_WORD;
                        end
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                RD_WORD: begin
                    if (wait_done) begin
                        wait_d  = '0;
                        data_d  = bus.d_mem_dout;
                        last_d  = (idx_q == cnt_q);
                        valid_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (idx_q == cnt_q) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = RD_WORD;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.d_mem_addra = addr_q;
    assign bus.d_mem_re    = (state_q == RD_CNT) || (state_q == RD_WORD);
    assign bus.d_mem_we    = 1'b0;
    assign bus.d_mem_din   = '0;
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_last    = last_q;
    assign busy            = (state_q != IDLE) && (state_q != DONE);
    assign done            = (state_q == DONE);
    assign cnt_clamped     = clamp_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_dmem_dump_reader.sv
// Self-checking bench for dmem_dump_reader: a behavioural memory plus a queue-based
// model of the expected word stream, cycle positions and done timing.
module tb_dmem_dump_reader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       cnt_clamped;
    logic [2:0] dbg_state;

    dmem_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .bus         (bus.master),
        .busy        (busy),
        .done        (done),
        .cnt_clamped (cnt_clamped),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) bus.d_mem_dout <= mem[bus.d_mem_addra];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    int                n_vec = 0;
    int                n_err = 0;
    int                t0 = 0;
    bit                mon_en = 0;
    logic [DATA_W-1:0] obs_data[$];
    bit                obs_last[$];
    int                obs_cyc[$];
    logic [DATA_W-1:0] stall_data[$];
    int                busy_cyc[$];
    int                done_seen;
    int                done_cyc;
    bit                we_seen;
    logic [ADDR_W-1:0] addr_c1;
    bit                re_c1;
    logic              post_valid;
    logic              post_busy;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid && bus.out_ready && !abort) begin
                obs_data.push_back(bus.out_data);
                obs_last.push_back(bus.out_last);
                obs_cyc.push_back(cyc - t0);
            end
            if (bus.out_valid && !bus.out_ready) stall_data.push_back(bus.out_data);
            if (busy) busy_cyc.push_back(cyc - t0);
            if (done) begin
                done_seen = done_seen + 1;
                done_cyc  = cyc - t0;
            end
            if (bus.d_mem_we !== 1'b0) we_seen = 1;
            if (cyc - t0 == 1) begin
                addr_c1 = bus.d_mem_addra;
                re_c1   = bus.d_mem_re;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    bit                exp_last_q[$];
    int                exp_n;
    bit                exp_clamp;

    task automatic build_expected();
        exp_q.delete();
        exp_last_q.delete();
        if (mem[0] >= 64'd256) begin
            exp_n     = 255;
            exp_clamp = 1;
        end else begin
            exp_n     = int'(mem[0]);
            exp_clamp = 0;
        end
        for (int i = 1; i <= exp_n; i++) begin
            exp_q.push_back(mem[i]);
            exp_last_q.push_back(i == exp_n);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'd3;
        mem[1] = 64'hA;
        mem[2] = 64'hB;
        mem[3] = 64'hC;
    endtask

    // ---------------- driver ----------------
    // ready_mode: 0 always ready, 1 stall word stall_word for stall_len cycles, 2 random ready + stray starts
    task automatic do_dump(input int ready_mode, input int stall_word, input int stall_len,
                           input int abort_word, input int max_cyc);
        int  stall_left;
        bit  aborted;
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
        stall_data.delete();
        busy_cyc.delete();
        done_seen  = 0;
        done_cyc   = -1;
        we_seen    = 0;
        addr_c1    = '1;
        re_c1      = 0;
        stall_left = stall_len;
        aborted    = 0;
        @(posedge clk); #1;
        start = 1; abort = 0; bus.out_ready = 1;
        t0 = cyc;
        mon_en = 1;
        for (int c = 0; c < max_cyc && done_seen == 0 && !aborted; c++) begin
            @(posedge clk); #1;
            start = 0; abort = 0; bus.out_ready = 1;
            if (bus.out_valid && obs_data.size() == abort_word) begin
                abort   = 1;
                aborted = 1;
            end else if (ready_mode == 1 && bus.out_valid && obs_data.size() == stall_word
                         && stall_left > 0) begin
                bus.out_ready = 0;
                stall_left--;
            end else if (ready_mode == 2) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                start = busy && ($urandom_range(0, 1) == 1);
            end
        end
        @(posedge clk); #1;
        start = 0; abort = 0; bus.out_ready = 1;
        post_valid = bus.out_valid;
        post_busy  = busy;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 0; start = 0; abort = 0; bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk); #1;
        n_vec++; if (bus.d_mem_addra !== '0) begin n_err++; $display("FAIL rst_addra got %h want 0", bus.d_mem_addra); end
        n_vec++; if (bus.d_mem_re !== 1'b0) begin n_err++; $display("FAIL rst_re got %b want 0", bus.d_mem_re); end
        n_vec++; if (bus.d_mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", bus.d_mem_we); end
        n_vec++; if (bus.d_mem_din !== '0) begin n_err++; $display("FAIL rst_din got %h want 0", bus.d_mem_din); end
        n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_data got %h want 0", bus.out_data); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rst_last got %b want 0", bus.out_last); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
        n_vec++; if (cnt_clamped !== 1'b0) begin n_err++; $display("FAIL rst_clamp got %b want 0", cnt_clamped); end
    endtask

    task automatic test_basic();
        load_basic();
        build_expected();
        do_dump(0, -1, 0, -1, 100);
        n_vec++; if (obs_data.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
            n_vec++; if (obs_data[k] !== exp_q[k]) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", k, obs_data[k], exp_q[k]); end
            n_vec++; if (obs_last[k] !== exp_last_q[k]) begin n_err++; $display("FAIL basic_last[%0d] got %b want %b", k, obs_last[k], exp_last_q[k]); end
            n_vec++; if (obs_cyc[k] != 3 * (k + 1) + 2) begin n_err++; $display("FAIL basic_cyc[%0d] got %0d want %0d", k, obs_cyc[k], 3 * (k + 1) + 2); end
        end
        n_vec++; if (done_seen != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", done_seen); end
        n_vec++; if (done_cyc != 3 * (exp_n + 1)) begin n_err++; $display("FAIL basic_done_cyc got %0d want %0d", done_cyc, 3 * (exp_n + 1)); end
        n_vec++; if (we_seen) begin n_err++; $display("FAIL basic_we got 1 want 0"); end
        n_vec++; if (cnt_clamped !== 1'b0) begin n_err++; $display("FAIL basic_clamp got %b want 0", cnt_clamped); end
        n_vec++; if (addr_c1 !== '0 || re_c1 !== 1'b1) begin n_err++; $display("FAIL basic_rdcnt got addr %h re %b want 0/1", addr_c1, re_c1); end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'd0;
        do_dump(0, -1, 0, -1, 50);
        n_vec++; if (obs_data.size() != 0) begin n_err++; $display("FAIL empty_count got %0d want 0", obs_data.size()); end
        n_vec++; if (done_cyc != 3) begin n_err++; $display("FAIL empty_done_cyc got %0d want 3", done_cyc); end
        n_vec++; if (busy_cyc.size() != 2) begin n_err++; $display("FAIL empty_busy_len got %0d want 2", busy_cyc.size()); end
        else begin
            n_vec++; if (busy_cyc[0] != 1 || busy_cyc[1] != 2) begin n_err++; $display("FAIL empty_busy_cyc got %0d,%0d want 1,2", busy_cyc[0], busy_cyc[1]); end
        end
    endtask

    task automatic test_stall();
        int stall_add;
        load_basic();
        build_expected();
        do_dump(1, 1, 4, -1, 100);
        n_vec++; if (obs_data.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
            stall_add = (k >= 1) ? 4 : 0;
            n_vec++; if (obs_data[k] !== exp_q[k]) begin n_err++; $display("FAIL stall_data[%0d] got %h want %h", k, obs_data[k], exp_q[k]); end
            n_vec++; if (obs_cyc[k] != 3 * (k + 1) + 2 + stall_add) begin n_err++; $display("FAIL stall_cyc[%0d] got %0d want %0d", k, obs_cyc[k], 3 * (k + 1) + 2 + stall_add); end
        end
        n_vec++; if (stall_data.size() != 4) begin n_err++; $display("FAIL stall_hold_len got %0d want 4", stall_data.size()); end
        foreach (stall_data[i]) begin
            n_vec++; if (stall_data[i] !== 64'hB) begin n_err++; $display("FAIL stall_hold[%0d] got %h want b", i, stall_data[i]); end
        end
        n_vec++; if (done_cyc != 16) begin n_err++; $display("FAIL stall_done_cyc got %0d want 16", done_cyc); end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h1_0000;
        build_expected();
        do_dump(0, -1, 0, -1, 1000);
        n_vec++; if (cnt_clamped !== 1'b1) begin n_err++; $display("FAIL clamp_flag got %b want 1", cnt_clamped); end
        n_vec++; if (obs_data.size() != 255) begin n_err++; $display("FAIL clamp_count got %0d want 255", obs_data.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
            n_vec++;
            if (obs_data[k] !== exp_q[k] || obs_last[k] !== exp_last_q[k]) begin
                n_err++; $display("FAIL clamp_word[%0d] got %h/%b want %h/%b", k, obs_data[k], obs_last[k], exp_q[k], exp_last_q[k]);
            end
        end
        n_vec++; if (done_cyc != 768) begin n_err++; $display("FAIL clamp_done_cyc got %0d want 768", done_cyc); end
    endtask

    task automatic test_abort();
        load_basic();
        build_expected();
        do_dump(0, -1, 0, 1, 100);
        n_vec++; if (post_valid !== 1'b0 || post_busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got valid %b busy %b want 0/0", post_valid, post_busy); end
        n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL abort_done got %0d want 0", done_seen); end
        n_vec++; if (obs_data.size() != 1) begin n_err++; $display("FAIL abort_count got %0d want 1", obs_data.size()); end
        n_vec++; if (bus.out_data !== 64'hB) begin n_err++; $display("FAIL abort_data_kept got %h want b", bus.out_data); end
        do_dump(0, -1, 0, -1, 100);
        n_vec++; if (addr_c1 !== '0) begin n_err++; $display("FAIL abort_restart_addr got %h want 0", addr_c1); end
        n_vec++; if (obs_data.size() != 3) begin n_err++; $display("FAIL abort_restart_count got %0d want 3", obs_data.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
            n_vec++; if (obs_data[k] !== exp_q[k]) begin n_err++; $display("FAIL abort_restart_data[%0d] got %h want %h", k, obs_data[k], exp_q[k]); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
            mem[0] = 64'($urandom_range(1, 12));
            build_expected();
            do_dump(2, -1, 0, -1, 600);
            n_vec++; if (obs_data.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count got %0d want %0d", it, obs_data.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < obs_data.size(); k++) begin
                n_vec++;
                if (obs_data[k] !== exp_q[k] || obs_last[k] !== exp_last_q[k]) begin
                    n_err++; $display("FAIL rand%0d_word[%0d] got %h/%b want %h/%b", it, k, obs_data[k], obs_last[k], exp_q[k], exp_last_q[k]);
                end
            end
            n_vec++; if (done_seen != 1) begin n_err++; $display("FAIL rand%0d_done_pulses got %0d want 1", it, done_seen); end
            n_vec++;
            if (done_cyc != 3 * (exp_n + 1) + stall_data.size()) begin
                n_err++; $display("FAIL rand%0d_done_cyc got %0d want %0d", it, done_cyc, 3 * (exp_n + 1) + stall_data.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        load_basic();
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        n_vec++; if (bus.d_mem_re !== 1'b1 || bus.d_mem_addra !== 8'd1 || busy !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre got re %b addr %h busy %b want 1/01/1", bus.d_mem_re, bus.d_mem_addra, busy);
        end
        #2;
        reset_n = 0;
        #1;
        n_vec++; if (bus.d_mem_re !== 1'b0 || bus.d_mem_addra !== '0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_async got re %b addr %h busy %b want 0/00/0", bus.d_mem_re, bus.d_mem_addra, busy);
        end
        n_vec++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || done !== 1'b0 || bus.out_data !== '0) begin
            n_err++; $display("FAIL midrst_outs got v %b l %b d %b data %h want 0/0/0/0", bus.out_valid, bus.out_last, done, bus.out_data);
        end
        start = 1;
        @(posedge clk); #1;
        start = 0;
        reset_n = 1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0 || cnt_clamped !== 1'b0) begin n_err++; $display("FAIL midrst_idle got busy %b clamp %b want 0/0", busy, cnt_clamped); end
    endtask

    initial begin
        start = 0;
        abort = 0;
        reset_n = 0;
        bus.out_ready = 1;
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_clamp();
        test_abort();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_dump_reader.md
# dmem_dump_reader

Hardware reader for the datapath's data-memory port, the counterpart of the bench-side word writer. On a start request it reads the word count held at address 0 and then walks addresses 1..N. Each 64-bit word is delivered on a valid/ready output stream, with a last flag on the final word. It sits between the datapath's d_mem port and the result-drain logic (FIFO/controller), so results can be read out after program execution without a testbench task.

## Interface
- ADDR_W, 8, data-memory address width
- DATA_W, 64, data-memory word width
- RD_LAT, 1, data-memory read latency in cycles (≥1), from d_mem_addra registered to d_mem_dout valid

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE from any state
- d_mem_addra  out  ADDR_W  registered read address
- d_mem_re  out  1  high in RD_CNT and RD_WORD
- d_mem_we  out  1  tied 0; the block never writes
- d_mem_din  out  DATA_W  tied 0
- d_mem_dout  in  DATA_W  read data, valid RD_LAT cycles after the address
- out_data  out  DATA_W  captured word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the word
- out_last  out  1  qualifies the final word (index == N)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse at completion
- cnt_clamped  out  1  sticky until next start; word 0 exceeded 2^ADDR_W−1

## Operation
- Reset values: state IDLE; d_mem_addra 0; d_mem_re 0; out_data 0; out_valid 0; out_last 0; busy 0; done 0; cnt_clamped 0; internal count and index 0.
- States: IDLE, RD_CNT, RD_WORD, SEND, DONE.
- IDLE: when start=1, go to RD_CNT, set d_mem_addra=0, and clear cnt_clamped.
- RD_CNT: lasts RD_LAT+1 cycles under a wait counter. At the end of the last cycle, latch N from d_mem_dout.
  - If d_mem_dout ≥ 2^ADDR_W: N = 2^ADDR_W−1 and cnt_clamped=1.
  - Otherwise N = d_mem_dout[ADDR_W−1:0].
  - If N==0, go to DONE.
  - Otherwise set index=1 and d_mem_addra=1, then go to RD_WORD.
- RD_WORD: lasts RD_LAT+1 cycles. On the last cycle, capture d_mem_dout into out_data, set out_last=(index==N), and go to SEND.
- SEND: out_valid=1; out_data and out_last are held stable until the handshake.
  - A handshake is out_valid & out_ready at a rising edge.
  - On handshake with index==N: out_valid=0, out_last=0, go to DONE.
  - On handshake otherwise: out_valid=0, index+1, d_mem_addra+1, go to RD_WORD.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort=1 in any state: next state is IDLE. out_valid, out_last, busy and d_mem_re are cleared, no done pulse is issued, and out_data keeps its value. abort takes precedence over start and over a same-cycle handshake.
- start while not in IDLE is ignored.
- Asserting reset_n low mid-operation immediately forces the reset values.
- Index arithmetic is ADDR_W bits. Because N ≤ 2^ADDR_W−1, the address never wraps.

## Timing
- Cycle 0 is the cycle in which start is sampled in IDLE.
- RD_CNT occupies cycles 1..RD_LAT+1.
- With out_ready held high, each word takes RD_LAT+2 cycles: RD_LAT+1 in RD_WORD and 1 in SEND.
- The first out_valid is asserted in cycle 2·RD_LAT+3.
- done is asserted in cycle (RD_LAT+2)·(N+1). For RD_LAT=1 that is 3(N+1); N=0 gives done in cycle 3.
- Each stall cycle (out_ready=0 in SEND) adds exactly one cycle.
- d_mem_addra changes only on RD_CNT/RD_WORD entry and is stable for the whole read window.
- The consumer must not rely on out_ready-to-out_valid combinational paths; out_valid is registered.

## Test plan
- Memory {0:3, 1:0xA, 2:0xB, 3:0xC}, RD_LAT=1, out_ready=1, start at cycle 0:
  - outputs 0xA, 0xB, 0xC, with out_valid in cycles 5, 8 and 11;
  - out_last only on 0xC;
  - done in cycle 12;
  - d_mem_we=0 throughout.
- mem[0]=0: no out_valid; done in cycle 3; busy high in cycles 1–2.
- Same data as the first scenario, out_ready low for 4 cycles on the second word:
  - 0xB is held stable with out_valid=1 for those 4 cycles;
  - done in cycle 16;
  - no word is dropped or repeated.
- mem[0]=0x1_0000 with ADDR_W=8: cnt_clamped=1, 255 words are streamed (addresses 1..255), and out_last is on address 255.
- abort during SEND of word 2, issued in the same cycle as out_ready=1:
  - next cycle is IDLE, with out_valid=0 and busy=0;
  - no done pulse;
  - a new start re-reads from address 0.
- reset_n pulsed low mid-RD_WORD: all outputs return to reset values asynchronously; start pulses during busy have no effect.
